// File: rtl/fetch_instruction.sv
// Instruction fetch stage: issues one-cycle-latency memory reads and buffers {inst, pc} in a 2-entry FIFO.
// Latency: request in cycle N, data returned N+1, presented to decode (v_o) in N+2.
// Backpressure: stall_i holds the FIFO head; requests throttle so the FIFO never overflows; branch_i flushes.
module fetch_instruction #(
   parameter int              WORD     = 32,
   parameter int              ADDR     = 32,
   parameter logic [ADDR-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_o,
   output logic [ADDR-1:0] imem_addr_o,
   input  logic            imem_rvalid_i,
   input  logic [WORD-1:0] imem_rdata_i,
   input  logic            branch_i,
   input  logic [ADDR-1:0] branch_pc_i,
   input  logic            stall_i,
   output logic            v_o,
   output logic [WORD-1:0] inst_o,
   output logic [ADDR-1:0] pc_o
);

   logic [1:0]      count_q, count_d;
   logic            rd_ptr_q, rd_ptr_d;
   logic            wr_ptr_q, wr_ptr_d;
   logic [WORD-1:0] inst_q [2];
   logic [WORD-1:0] inst_d [2];
   logic [ADDR-1:0] pc_q [2];
   logic [ADDR-1:0] pc_d [2];
   logic [ADDR-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR-1:0] req_pc_q, req_pc_d;
   logic            inflight_q, inflight_d;
   logic            discard_q, discard_d;

   logic            deq;
   logic            enq;
   logic            req;
   logic [2:0]      occ;

   // Handshake decisions: a response only counts if we actually asked for it and no flush kills it.
   always_comb begin
      deq = reset && (count_q != 2'd0) && !stall_i && !branch_i;
      enq = reset && imem_rvalid_i && inflight_q && !discard_q && !branch_i;
      occ = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, deq};
      req = reset && !branch_i && (occ < 3'd2);
   end

   // Next-state for FIFO, fetch PC and in-flight bookkeeping; a branch overrides everything else.
   always_comb begin
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      inst_d     = inst_q;
      pc_d       = pc_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = req;
      discard_d  = branch_i;

      if (branch_i) begin
         count_d    = 2'd0;
         rd_ptr_d   = 1'b0;
         wr_ptr_d   = 1'b0;
         fetch_pc_d = branch_pc_i;
      end else begin
         if (enq) begin
            inst_d[wr_ptr_q] = imem_rdata_i;
            pc_d[wr_ptr_q]   = req_pc_q;
            wr_ptr_d         = ~wr_ptr_q;
         end
         if (deq) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         case ({enq, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
         if (req) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + ADDR'(4);
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q    <= 2'd0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
         discard_q  <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            inst_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else begin
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         inst_q     <= inst_d;
         pc_q       <= pc_d;
      end
   end

   // Outputs: head of FIFO straight from registers, forced quiet while in reset.
   always_comb begin
      imem_req_o  = req;
      imem_addr_o = fetch_pc_q;
      v_o         = reset && (count_q != 2'd0);
      inst_o      = reset ? inst_q[rd_ptr_q] : '0;
      pc_o        = reset ? pc_q[rd_ptr_q]   : '0;
   end

endmodule
